board_clear_unit: RTL and testbench
===================================

# board_clear_unit

Playfield store and line-clear engine, directly downstream of the game-state FSM. On each lock pulse it ORs the four cells of the active piece into a 10×20 occupancy board. It then scans every row bottom-up and collapses each full row by shifting all rows above it down one place. It exports the board through a read port for the renderer and collision logic, plus per-row full flags, a busy/done handshake and the number of lines cleared.

## Interface
Parameters:
- BOARD_W, 10, columns per row (bit x of a row = column x)
- BOARD_H, 20, rows; row 0 = top, row BOARD_H-1 = bottom

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high; clears board and all state
- lock_i  in  1  one-cycle request to commit the current piece; sampled only in IDLE
- clear_board_i  in  1  wipe the whole board (new game); sampled only in IDLE, lower priority than lock_i
- x0..x3  in  5 each  piece cell columns, sampled with lock_i
- y0..y3  in  6 each  piece cell rows, sampled with lock_i
- rd_row  in  5  renderer/collision read address
- rd_data  out  10  combinational board[rd_row]; 0 when rd_row ≥ BOARD_H
- row_full  out  20  row_full[r] = &board[r], combinational from registers
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when a lock sequence completes
- lines_cleared  out  3  rows removed by the last lock (0..4); held until the next accepted lock

## Operation
- States: IDLE, WRITE, SCAN, SHIFT, DONE.
- IDLE behaviour:
  - lock_i=1: latch the eight coordinates and go to WRITE.
  - Otherwise, clear_board_i=1: all rows become 0 in one cycle; stay in IDLE.
- WRITE (1 cycle):
  - Set board[yi][xi] for each cell with xi < BOARD_W and yi < BOARD_H; out-of-range cells are silently dropped.
  - Duplicate coordinates are harmless (OR).
  - lines_cleared ← 0; scan_row ← BOARD_H-1; go to SCAN.
- SCAN (1 cycle per row):
  - If board[scan_row] is full: shift_row ← scan_row; go to SHIFT.
  - Else, if scan_row = 0: go to DONE.
  - Else: scan_row ← scan_row-1.
- SHIFT (1 row per cycle):
  - If shift_row > 0: board[shift_row] ← board[shift_row-1]; shift_row ← shift_row-1.
  - If shift_row = 0: board[0] ← 0; lines_cleared ← lines_cleared+1 (saturate at 7); return to SCAN with scan_row unchanged, so the row that dropped in is rescanned.
- DONE (1 cycle): done=1; go to IDLE.
- lock_i and clear_board_i outside IDLE are ignored; there is no queueing.
- Reset at any point, including mid-SHIFT: board all 0, state IDLE, scan_row/shift_row 0, all outputs 0 asynchronously.

## Timing
- Reset values: busy=0, done=0, lines_cleared=0, row_full=0, rd_data=0.
- Cycle numbering: lock_i is sampled at the edge ending cycle t.
  - t+1: WRITE.
  - t+2 onward: SCAN at row BOARD_H-1.
- No full rows: 20 SCAN cycles (t+2..t+21), DONE at t+22, busy high t+1..t+22.
- Each cleared row at index r adds r+1 SHIFT cycles plus 1 rescan cycle. A single bottom-row clear puts DONE at t+43.
- Worst case (four rows cleared at 16..19): DONE at t+22+4·21 = t+106.
- rd_data and row_full reflect the board registers with zero latency. During WRITE/SHIFT they may show intermediate board contents; consumers must gate on busy=0.
- clear_board_i takes effect at the next edge; busy stays 0.

## Structure
- Shared package tetris_pkg:
  - BOARD_W and BOARD_H constants.
  - board_row_t (logic [BOARD_W-1:0]).
  - Enum clr_state_t {IDLE, WRITE, SCAN, SHIFT, DONE}.
  - Both this block and the game-state FSM import the package.
- Single module with no sub-module. The board is a register array, not RAM, because row_full needs parallel access and SHIFT writes one row per cycle.

## Test plan
- Reset, then read all rows → rd_data=0, row_full=0, busy=0, done=0, lines_cleared=0.
- Lock cells (0,19),(1,19),(2,19),(3,19) → board[19]=10'h00F, done at t+22, lines_cleared=0.
- With board[19]=10'h03F and board[18]=10'h001, lock (6,19),(7,19),(8,19),(9,19) → done at t+43, board[19]=10'h001, board[18]=0, lines_cleared=1.
- Rows 16..19 each preset to 10'h1FF and board[15]=10'h200; lock (9,16),(9,17),(9,18),(9,19) → lines_cleared=4, board[19]=10'h200, rows 0..18=0, done at t+106.
- Lock with (12,3) and (4,25) in range of x/y ports → those cells are dropped, the other two are written. Pulse lock_i again while busy=1 → ignored, with exactly one done pulse.
- Assert reset during SHIFT → busy=0 and all rows 0 immediately. A following clear_board_i in IDLE keeps the board at 0 and busy at 0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared playfield definitions for the game-state FSM and the board/line-clear engine.
// Provides board dimensions, coordinate widths, the row type, the clear-engine state
// enum and a helper that turns one piece cell into a row bit mask.
package tetris_pkg;

    localparam int unsigned BOARD_W = 10;   // columns per row, bit x = column x
    localparam int unsigned BOARD_H = 20;   // rows, row 0 = top
    localparam int unsigned ROW_AW  = 5;    // row address width (scan/shift/read)
    localparam int unsigned X_W     = 5;    // piece column coordinate width
    localparam int unsigned Y_W     = 6;    // piece row coordinate width
    localparam int unsigned LC_W    = 3;    // lines_cleared width

    typedef logic [BOARD_W-1:0] board_row_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SCAN,
        SHIFT,
        DONE
    } clr_state_t;

    // Bit mask contributed to board row 'row' by cell (x, y); off-board cells give 0.
    function automatic board_row_t cell_bit(input logic [X_W-1:0] x,
                                            input logic [Y_W-1:0] y,
                                            input int unsigned    row);
        board_row_t m;
        m = '0;
        if ((x < X_W'(BOARD_W)) && (y == Y_W'(row)))
            m = board_row_t'(1) << x;
        return m;
    endfunction

endpackage

// File: rtl/board_clear_unit_if.sv
// Bus between the game-state FSM / renderer (master) and board_clear_unit (slave).
// master drives: lock_i, clear_board_i, x0..x3, y0..y3, rd_row
// slave drives:  rd_data, row_full, busy, done, lines_cleared
interface board_clear_unit_if;
    import tetris_pkg::*;

    logic                lock_i;
    logic                clear_board_i;
    logic [X_W-1:0]      x0, x1, x2, x3;
    logic [Y_W-1:0]      y0, y1, y2, y3;
    logic [ROW_AW-1:0]   rd_row;
    board_row_t          rd_data;
    logic [BOARD_H-1:0]  row_full;
    logic                busy;
    logic                done;
    logic [LC_W-1:0]     lines_cleared;

    modport master (
        output lock_i, clear_board_i, x0, x1, x2, x3, y0, y1, y2, y3, rd_row,
        input  rd_data, row_full, busy, done, lines_cleared
    );

    modport slave (
        input  lock_i, clear_board_i, x0, x1, x2, x3, y0, y1, y2, y3, rd_row,
        output rd_data, row_full, busy, done, lines_cleared
    );

endinterface

// File: rtl/board_clear_unit.sv
// Playfield store and line-clear engine.
// On lock_i it ORs four piece cells into the 10x20 board, then scans rows bottom-up
// and collapses every full row by shifting the rows above it down one per cycle.
// Ports: clk, reset (async, active-high), bus (board_clear_unit_if.slave):
//   lock_i/clear_board_i/x0..x3/y0..y3 commands, rd_row/rd_data read port,
//   row_full flags, busy/done handshake, lines_cleared count of the last lock.
module board_clear_unit
    import tetris_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    board_clear_unit_if.slave bus
);

    clr_state_t              state;
    board_row_t              board   [BOARD_H];
    board_row_t              board_d [BOARD_H];
    logic [BOARD_H-1:0]      full;
    logic [ROW_AW-1:0]       scan_row;
    logic [ROW_AW-1:0]       shift_row;
    logic [3:0][X_W-1:0]     x_q;
    logic [3:0][Y_W-1:0]     y_q;
    logic [LC_W-1:0]         lines_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    wipe;

    // New-game wipe only when idle and no lock competes for the cycle.
    assign wipe = (state == IDLE) && !bus.lock_i && bus.clear_board_i;

    // Per-row next value: wipe, piece write, or shift-in from the row above.
    for (genvar r = 0; r < BOARD_H; r++) begin : g_row
        board_row_t shift_in;
        board_row_t wr_mask;
        logic       shift_hit;

        if (r == 0) begin : g_top
            assign shift_in = '0;
        end else begin : g_rest
            assign shift_in = board[r-1];
        end

        assign wr_mask   = cell_bit(x_q[0], y_q[0], r) | cell_bit(x_q[1], y_q[1], r)
                         | cell_bit(x_q[2], y_q[2], r) | cell_bit(x_q[3], y_q[3], r);
        assign shift_hit = (state == SHIFT) && (shift_row == ROW_AW'(r));
        assign board_d[r] = wipe             ? '0
                          : (state == WRITE) ? (board[r] | wr_mask)
                          : shift_hit        ? shift_in
                          :                    board[r];
        assign full[r] = &board[r];
    end

    // Board register array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board <= '{default: '0};
        end else begin
            board <= board_d;
        end
    end

    // Lock sequencing FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            scan_row  <= '0;
            shift_row <= '0;
            x_q       <= '0;
            y_q       <= '0;
            lines_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.lock_i) begin
                        x_q    <= {bus.x3, bus.x2, bus.x1, bus.x0};
                        y_q    <= {bus.y3, bus.y2, bus.y1, bus.y0};
                        busy_q <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    lines_q  <= '0;
                    scan_row <= ROW_AW'(BOARD_H - 1);
                    state    <= SCAN;
                end
                SCAN: begin
                    if (full[scan_row]) begin
                        shift_row <= scan_row;
                        state     <= SHIFT;
                    end else if (scan_row == '0) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        scan_row <= scan_row - ROW_AW'(1);
                    end
                end
                SHIFT: begin
                    // scan_row is left alone so the row that dropped in gets rescanned.
                    if (shift_row != '0) begin
                        shift_row <= shift_row - ROW_AW'(1);
                    end else begin
                        if (lines_q != '1)
                            lines_q <= lines_q + LC_W'(1);
                        state <= SCAN;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_data       = (bus.rd_row < ROW_AW'(BOARD_H)) ? board[bus.rd_row] : '0;
    assign bus.row_full      = full;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.lines_cleared = lines_q;

endmodule

// File: tb/tb_board_clear_unit.sv
// Self-checking bench for board_clear_unit: directed scenarios plus randomized locks
// checked against a row-list reference model of the playfield.
module tb_board_clear_unit;
    import tetris_pkg::*;

    typedef logic [3:0][4:0]  xv_t;
    typedef logic [3:0][5:0]  yv_t;
    typedef logic [19:0][9:0] rows_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [9:0] mb [20];

    always #5 clk = ~clk;

    board_clear_unit_if bus();

    board_clear_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference: OR cells, drop full rows keeping the others in order, pad zeros on top.
    // A full row found at original index f after c lower clears is removed at index f+c,
    // costing (f+c+1) shift cycles plus one rescan cycle.
    task automatic model_lock(input xv_t xs, input yv_t ys, output int lines,
                              output int lat, output logic [19:0] fullv);
        logic [9:0] keep[$];
        for (int i = 0; i < 4; i++)
            if (int'(xs[i]) < 10 && int'(ys[i]) < 20)
                mb[int'(ys[i])][int'(xs[i])] = 1'b1;
        fullv = '0;
        for (int r = 0; r < 20; r++) fullv[r] = &mb[r];
        lines = 0;
        lat   = 22;
        for (int r = 19; r >= 0; r--) begin
            if (&mb[r]) begin
                lat   += r + lines + 2;
                lines += 1;
            end else begin
                keep.push_back(mb[r]);
            end
        end
        if (lines > 7) lines = 7;
        for (int r = 19; r >= 0; r--)
            mb[r] = ((19 - r) < keep.size()) ? keep[19 - r] : 10'h000;
    endtask

    task automatic model_wipe();
        for (int r = 0; r < 20; r++) mb[r] = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #3;
        @(negedge clk);
        reset = 1'b0;
        model_wipe();
    endtask

    // Drive one lock and observe until done (bounded). lat=-1 on timeout.
    task automatic do_lock(input xv_t xs, input yv_t ys, input int repulse_at,
                           output int lat, output int busy_cnt,
                           output logic [19:0] rf2, output logic [2:0] lc);
        @(negedge clk);
        bus.x0 = xs[0]; bus.x1 = xs[1]; bus.x2 = xs[2]; bus.x3 = xs[3];
        bus.y0 = ys[0]; bus.y1 = ys[1]; bus.y2 = ys[2]; bus.y3 = ys[3];
        bus.lock_i = 1'b1;
        @(negedge clk);
        bus.lock_i = 1'b0;
        lat = -1; busy_cnt = 0; rf2 = '0; lc = '0;
        for (int n = 1; n <= 300; n++) begin
            if (bus.busy) busy_cnt++;
            if (n == 2) rf2 = bus.row_full;
            if (bus.done) begin
                lat = n;
                lc  = bus.lines_cleared;
                break;
            end
            bus.lock_i = (n == repulse_at);
            if (n == repulse_at) begin
                bus.x0 = 5'd5; bus.x1 = 5'd5; bus.x2 = 5'd5; bus.x3 = 5'd5;
                bus.y0 = 6'd5; bus.y1 = 6'd5; bus.y2 = 6'd5; bus.y3 = 6'd5;
            end
            @(negedge clk);
        end
        bus.lock_i = 1'b0;
    endtask

    task automatic read_board(output rows_t rows);
        for (int r = 0; r < 20; r++) begin
            bus.rd_row = 5'(r);
            #1;
            rows[r] = bus.rd_data;
        end
    endtask

    task automatic test_reset();
        rows_t rows;
        reset = 1'b1;
        #23;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.lines_cleared !== 3'd0) begin bad++; $display("FAIL reset_lines got=%0d want=0", bus.lines_cleared); end
        total++; if (bus.row_full !== 20'h0) begin bad++; $display("FAIL reset_row_full got=%h want=0", bus.row_full); end
        @(negedge clk);
        reset = 1'b0;
        model_wipe();
        read_board(rows);
        for (int r = 0; r < 20; r++) begin
            total++;
            if (rows[r] !== 10'h000) begin bad++; $display("FAIL reset_row%0d got=%h want=000", r, rows[r]); end
        end
    endtask

    task automatic test_no_clear();
        int lat, bc, lines, elat; logic [19:0] rf2, efull; logic [2:0] lc; rows_t rows;
        apply_reset();
        do_lock({5'd3, 5'd2, 5'd1, 5'd0}, {4{6'd19}}, 0, lat, bc, rf2, lc);
        model_lock({5'd3, 5'd2, 5'd1, 5'd0}, {4{6'd19}}, lines, elat, efull);
        total++; if (lat !== 22) begin bad++; $display("FAIL noclr_latency got=%0d want=22", lat); end
        total++; if (bc !== 22) begin bad++; $display("FAIL noclr_busy_cycles got=%0d want=22", bc); end
        total++; if (lc !== 3'd0) begin bad++; $display("FAIL noclr_lines got=%0d want=0", lc); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL noclr_after got=%b%b want=00", bus.busy, bus.done); end
        read_board(rows);
        total++; if (rows[19] !== 10'h00F) begin bad++; $display("FAIL noclr_row19 got=%h want=00F", rows[19]); end
        for (int r = 0; r < 20; r++) begin
            total++;
            if (rows[r] !== mb[r]) begin bad++; $display("FAIL noclr_row%0d got=%h want=%h", r, rows[r], mb[r]); end
        end
    endtask

    task automatic test_single_clear();
        int lat, bc, lines, elat; logic [19:0] rf2, efull; logic [2:0] lc; rows_t rows;
        apply_reset();
        do_lock({5'd3, 5'd2, 5'd1, 5'd0}, {4{6'd19}}, 0, lat, bc, rf2, lc);
        model_lock({5'd3, 5'd2, 5'd1, 5'd0}, {4{6'd19}}, lines, elat, efull);
        do_lock({5'd0, 5'd0, 5'd5, 5'd4}, {6'd18, 6'd18, 6'd19, 6'd19}, 0, lat, bc, rf2, lc);
        model_lock({5'd0, 5'd0, 5'd5, 5'd4}, {6'd18, 6'd18, 6'd19, 6'd19}, lines, elat, efull);
        total++; if (lat !== 22) begin bad++; $display("FAIL single_setup_latency got=%0d want=22", lat); end
        do_lock({5'd9, 5'd8, 5'd7, 5'd6}, {4{6'd19}}, 0, lat, bc, rf2, lc);
        model_lock({5'd9, 5'd8, 5'd7, 5'd6}, {4{6'd19}}, lines, elat, efull);
        total++; if (lat !== 43) begin bad++; $display("FAIL single_latency got=%0d want=43", lat); end
        total++; if (bc !== 43) begin bad++; $display("FAIL single_busy_cycles got=%0d want=43", bc); end
        total++; if (lc !== 3'd1) begin bad++; $display("FAIL single_lines got=%0d want=1", lc); end
        total++; if (rf2 !== 20'h80000) begin bad++; $display("FAIL single_row_full got=%h want=80000", rf2); end
        read_board(rows);
        total++; if (rows[19] !== 10'h001) begin bad++; $display("FAIL single_row19 got=%h want=001", rows[19]); end
        total++; if (rows[18] !== 10'h000) begin bad++; $display("FAIL single_row18 got=%h want=000", rows[18]); end
        for (int r = 0; r < 20; r++) begin
            total++;
            if (rows[r] !== mb[r]) begin bad++; $display("FAIL single_row%0d got=%h want=%h", r, rows[r], mb[r]); end
        end
    endtask

    task automatic test_quad_clear();
        int lat, bc, lines, elat; logic [19:0] rf2, efull; logic [2:0] lc; rows_t rows;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            do_lock({4{5'(c)}}, {6'd19, 6'd18, 6'd17, 6'd16}, 0, lat, bc, rf2, lc);
            model_lock({4{5'(c)}}, {6'd19, 6'd18, 6'd17, 6'd16}, lines, elat, efull);
            total++; if (lat !== elat) begin bad++; $display("FAIL quad_setup%0d_latency got=%0d want=%0d", c, lat, elat); end
        end
        do_lock({4{5'd9}}, {4{6'd15}}, 0, lat, bc, rf2, lc);
        model_lock({4{5'd9}}, {4{6'd15}}, lines, elat, efull);
        do_lock({4{5'd9}}, {6'd19, 6'd18, 6'd17, 6'd16}, 0, lat, bc, rf2, lc);
        model_lock({4{5'd9}}, {6'd19, 6'd18, 6'd17, 6'd16}, lines, elat, efull);
        total++; if (lat !== 106) begin bad++; $display("FAIL quad_latency got=%0d want=106", lat); end
        total++; if (lc !== 3'd4) begin bad++; $display("FAIL quad_lines got=%0d want=4", lc); end
        total++; if (rf2 !== 20'hF0000) begin bad++; $display("FAIL quad_row_full got=%h want=F0000", rf2); end
        read_board(rows);
        total++; if (rows[19] !== 10'h200) begin bad++; $display("FAIL quad_row19 got=%h want=200", rows[19]); end
        for (int r = 0; r < 20; r++) begin
            total++;
            if (rows[r] !== mb[r]) begin bad++; $display("FAIL quad_row%0d got=%h want=%h", r, rows[r], mb[r]); end
        end
    endtask

    task automatic test_drop_and_ignore();
        int lat, bc, lines, elat, extra_done, extra_busy; logic [19:0] rf2, efull; logic [2:0] lc; rows_t rows;
        apply_reset();
        do_lock({5'd2, 5'd1, 5'd4, 5'd12}, {6'd2, 6'd2, 6'd25, 6'd3}, 5, lat, bc, rf2, lc);
        model_lock({5'd2, 5'd1, 5'd4, 5'd12}, {6'd2, 6'd2, 6'd25, 6'd3}, lines, elat, efull);
        total++; if (lat !== 22) begin bad++; $display("FAIL drop_latency got=%0d want=22", lat); end
        extra_done = 0; extra_busy = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
            if (bus.busy) extra_busy++;
        end
        total++; if (extra_done !== 0) begin bad++; $display("FAIL ignore_extra_done got=%0d want=0", extra_done); end
        total++; if (extra_busy !== 0) begin bad++; $display("FAIL ignore_extra_busy got=%0d want=0", extra_busy); end
        read_board(rows);
        total++; if (rows[2] !== 10'h006) begin bad++; $display("FAIL drop_row2 got=%h want=006", rows[2]); end
        for (int r = 0; r < 20; r++) begin
            total++;
            if (rows[r] !== mb[r]) begin bad++; $display("FAIL drop_row%0d got=%h want=%h", r, rows[r], mb[r]); end
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat, bc, lines, elat; logic [19:0] rf2, efull; logic [2:0] lc; rows_t rows;
        apply_reset();
        do_lock({5'd3, 5'd2, 5'd1, 5'd0}, {4{6'd19}}, 0, lat, bc, rf2, lc);
        do_lock({5'd7, 5'd6, 5'd5, 5'd4}, {4{6'd19}}, 0, lat, bc, rf2, lc);
        @(negedge clk);
        bus.x0 = 5'd8; bus.x1 = 5'd9; bus.x2 = 5'd0; bus.x3 = 5'd0;
        bus.y0 = 6'd19; bus.y1 = 6'd19; bus.y2 = 6'd0; bus.y3 = 6'd0;
        bus.lock_i = 1'b1;
        @(negedge clk);
        bus.lock_i = 1'b0;
        repeat (7) @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midshift_busy_before got=%b want=1", bus.busy); end
        #2 reset = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midshift_busy got=%b want=0", bus.busy); end
        total++; if (bus.row_full !== 20'h0) begin bad++; $display("FAIL midshift_row_full got=%h want=0", bus.row_full); end
        total++; if (bus.lines_cleared !== 3'd0 || bus.done !== 1'b0) begin bad++; $display("FAIL midshift_outs got=%0d/%b want=0/0", bus.lines_cleared, bus.done); end
        read_board(rows);
        for (int r = 0; r < 20; r++) begin
            total++;
            if (rows[r] !== 10'h000) begin bad++; $display("FAIL midshift_row%0d got=%h want=000", r, rows[r]); end
        end
        @(negedge clk);
        reset = 1'b0;
        model_wipe();
        bus.clear_board_i = 1'b1;
        @(negedge clk);
        bus.clear_board_i = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%b want=0", bus.busy); end
        read_board(rows);
        for (int r = 0; r < 20; r++) begin
            total++;
            if (rows[r] !== 10'h000) begin bad++; $display("FAIL clear_row%0d got=%h want=000", r, rows[r]); end
        end
    endtask

    task automatic test_random();
        int lat, bc, lines, elat, rep; logic [19:0] rf2, efull; logic [2:0] lc; rows_t rows;
        xv_t xs; yv_t ys;
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                bus.clear_board_i = 1'b1;
                @(negedge clk);
                bus.clear_board_i = 1'b0;
                model_wipe();
                total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_clear_busy got=%b want=0", it, bus.busy); end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    xs[i] = 5'($urandom_range(0, 11));
                    ys[i] = 6'($urandom_range(14, 21));
                end
                rep = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 30));
                do_lock(xs, ys, rep, lat, bc, rf2, lc);
                model_lock(xs, ys, lines, elat, efull);
                total++; if (lat !== elat) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", it, lat, elat); end
                total++; if (bc !== elat) begin bad++; $display("FAIL rnd%0d_busy_cycles got=%0d want=%0d", it, bc, elat); end
                total++; if (int'(lc) !== lines) begin bad++; $display("FAIL rnd%0d_lines got=%0d want=%0d", it, lc, lines); end
                total++; if (rf2 !== efull) begin bad++; $display("FAIL rnd%0d_row_full got=%h want=%h", it, rf2, efull); end
                @(negedge clk);
                total++; if (int'(bus.lines_cleared) !== lines) begin bad++; $display("FAIL rnd%0d_lines_held got=%0d want=%0d", it, bus.lines_cleared, lines); end
            end
            read_board(rows);
            for (int r = 0; r < 20; r++) begin
                total++;
                if (rows[r] !== mb[r]) begin bad++; $display("FAIL rnd%0d_row%0d got=%h want=%h", it, r, rows[r], mb[r]); end
            end
        end
        // Make sure the board is non-empty, then probe addresses past the bottom row.
        do_lock({5'd0, 5'd1, 5'd2, 5'd3}, {6'd0, 6'd0, 6'd0, 6'd0}, 0, lat, bc, rf2, lc);
        model_lock({5'd0, 5'd1, 5'd2, 5'd3}, {6'd0, 6'd0, 6'd0, 6'd0}, lines, elat, efull);
        @(negedge clk);
        for (int a = 20; a < 32; a++) begin
            bus.rd_row = 5'(a);
            #1;
            total++;
            if (bus.rd_data !== 10'h000) begin bad++; $display("FAIL rd_oob%0d got=%h want=000", a, bus.rd_data); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.lock_i = 1'b0;
        bus.clear_board_i = 1'b0;
        bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
        bus.y0 = '0; bus.y1 = '0; bus.y2 = '0; bus.y3 = '0;
        bus.rd_row = '0;
        test_reset();
        test_no_clear();
        test_single_clear();
        test_quad_clear();
        test_drop_and_ignore();
        test_reset_mid_shift();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
